window_multiplier: RTL and testbench

Parametrised, streaming time-domain window for the FFT front end. It multiplies each complex sample of an N-point frame by a selectable window coefficient (rectangular, Hann, Hamming, Blackman) with full valid/ready back-pressure. It replaces the fixed-width, single-channel, Hann-only multiplier and sits between the DDC output and the FFT input, marking the last sample of every frame.

---
 rtl/window_multiplier_pkg.sv | 21 ++
 rtl/window_multiplier_if.sv | 17 +
 rtl/window_multiplier_rom.sv | 23 ++
 rtl/window_multiplier.sv | 70 +++++++
 tb/tb_window_multiplier.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/window_multiplier_pkg.sv
// window_multiplier_pkg: window types and coefficient math shared by the window multiplier.
package window_multiplier_pkg;
  typedef enum logic [1:0] {RECT, HANN, HAMMING, BLACKMAN} window_t;
  localparam real PI = 3.14159265358979323846;
  function automatic real window_f(window_t w, int n, int frame_log2);
    real x;
    x = 2.0 * PI * n / ((2 ** frame_log2) - 1);
    return w == HANN ? 0.5 - 0.5 * $cos(x) :
           w == HAMMING ? 0.54 - 0.46 * $cos(x) :
           w == BLACKMAN ? 0.42 - 0.5 * $cos(x) + 0.08 * $cos(2.0 * x) : 1.0;
  endfunction
  // Blackman evaluates a hair below zero at the frame ends; clamp before rounding.
  function automatic int coef_val(window_t w, int n, int frame_log2, int coef_width);
    real f;
    f = window_f(w, n, frame_log2);
    return $rtoi((f < 0.0 ? 0.0 : f) * real'((1 << coef_width) - 1) + 0.5);
  endfunction
  function automatic longint rnd_const(int coef_width);
    return 64'sd1 <<< (coef_width - 1);
  endfunction
endpackage

// File: rtl/window_multiplier_if.sv
// window_multiplier_if: sample stream in, windowed stream out, plus window select.
interface window_multiplier_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_q;
  logic valid;
  logic ready;
  logic [1:0] window_sel;
  logic [DATA_WIDTH-1:0] res_i;
  logic [DATA_WIDTH-1:0] res_q;
  logic res_valid;
  logic res_ready;
  logic res_last;
  modport master (output data_i, data_q, valid, window_sel, res_ready,
                  input ready, res_i, res_q, res_valid, res_last);
  modport slave (input data_i, data_q, valid, window_sel, res_ready,
                 output ready, res_i, res_q, res_valid, res_last);
endinterface

// File: rtl/window_multiplier_rom.sv
// window_multiplier_rom: half-frame coefficient ROM for all windows, one-cycle registered read.
module window_multiplier_rom
  import window_multiplier_pkg::*;
#(
  parameter int COEF_WIDTH = 18,
  parameter int FRAME_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  window_t               win,
  input  logic [FRAME_LOG2-2:0] addr,
  output logic [COEF_WIDTH-1:0] coef
);
  localparam int HALF = 2 ** (FRAME_LOG2 - 1);
  logic [COEF_WIDTH-1:0] rom [4][HALF];
  for (genvar w = 0; w < 4; w++) begin : g_w
    for (genvar a = 0; a < HALF; a++) begin : g_a
      assign rom[w][a] = COEF_WIDTH'(coef_val(window_t'(w), a, FRAME_LOG2, COEF_WIDTH));
    end
  end
  always_ff @(posedge clk)
    if (en) coef <= rom[win][addr];
endmodule

// File: rtl/window_multiplier.sv
// window_multiplier: streaming I/Q frame window (rect/Hann/Hamming/Blackman), 3-stage pipeline
// with whole-pipeline valid/ready stall and end-of-frame marker.
module window_multiplier
  import window_multiplier_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int COEF_WIDTH = 18,
  parameter int FRAME_LOG2 = 10
) (
  input logic i_clk,
  input logic i_resetn,
  window_multiplier_if.slave bus
);
  localparam int PW = DATA_WIDTH + COEF_WIDTH + 1;
  localparam logic signed [PW-1:0] RND = PW'(rnd_const(COEF_WIDTH));
  logic advance, accept, v1, v2, last1, last2, rect1;
  logic [FRAME_LOG2-1:0] n;
  logic [FRAME_LOG2-2:0] addr;
  window_t win_q, win_cur;
  logic [DATA_WIDTH-1:0] d1_i, d1_q;
  logic [COEF_WIDTH-1:0] coef;
  logic signed [PW-1:0] p_i, p_q;
  always_comb begin
    advance = !bus.res_valid || bus.res_ready;
    accept = bus.valid && advance;
    win_cur = n == '0 ? window_t'(bus.window_sel) : win_q;
    addr = n[FRAME_LOG2-1] ? ~n[FRAME_LOG2-2:0] : n[FRAME_LOG2-2:0];
  end
  assign bus.ready = advance;
  window_multiplier_rom #(.COEF_WIDTH(COEF_WIDTH), .FRAME_LOG2(FRAME_LOG2)) u_rom (
    .clk(i_clk), .en(advance), .win(win_cur), .addr(addr), .coef(coef)
  );
  // Rect feeds data pre-scaled by 2^COEF_WIDTH so the shared round/shift returns it unchanged.
  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) begin
      n <= '0;
      win_q <= RECT;
      v1 <= 1'b0;
      v2 <= 1'b0;
      last1 <= 1'b0;
      last2 <= 1'b0;
      rect1 <= 1'b1;
      d1_i <= '0;
      d1_q <= '0;
      p_i <= '0;
      p_q <= '0;
      bus.res_valid <= 1'b0;
      bus.res_last <= 1'b0;
      bus.res_i <= '0;
      bus.res_q <= '0;
    end else if (advance) begin
      if (accept) n <= n + FRAME_LOG2'(1);
      if (accept && n == '0) win_q <= win_cur;
      v1 <= bus.valid;
      last1 <= accept && &n;
      rect1 <= win_cur == RECT;
      d1_i <= bus.data_i;
      d1_q <= bus.data_q;
      v2 <= v1;
      last2 <= last1;
      p_i <= rect1 ? $signed({d1_i[DATA_WIDTH-1], d1_i, {COEF_WIDTH{1'b0}}})
                   : PW'($signed(d1_i)) * PW'($signed({1'b0, coef}));
      p_q <= rect1 ? $signed({d1_q[DATA_WIDTH-1], d1_q, {COEF_WIDTH{1'b0}}})
                   : PW'($signed(d1_q)) * PW'($signed({1'b0, coef}));
      bus.res_valid <= v2;
      bus.res_last <= last2;
      bus.res_i <= DATA_WIDTH'((p_i + RND) >>> COEF_WIDTH);
      bus.res_q <= DATA_WIDTH'((p_q + RND) >>> COEF_WIDTH);
    end
endmodule

// File: tb/tb_window_multiplier.sv
// tb_window_multiplier: randomized bench checking the window multiplier against a behavioural model.
module tb_window_multiplier;
  localparam int DW = 32, CW = 18, LOG2 = 4, N = 16;
  localparam real PI = 3.14159265358979323846;
  typedef struct {
    int n;
    longint in_mag;
    logic [31:0] ei;
    logic [31:0] eq;
    logic el;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, failures = 0, cyc = 0;
  int mn = 0, mwin = 0, last_cnt = 0, t0 = -1, t1 = -1;
  bit lat_arm = 0, rand_rdy = 0, held = 0;
  logic [31:0] hi, hq;
  logic hl;
  logic [31:0] got_i [N];
  int out_cyc [N];
  exp_t q[$];
  exp_t e, r;

  window_multiplier_if #(.DATA_WIDTH(DW)) bus ();
  window_multiplier #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .FRAME_LOG2(LOG2)) dut (
    .i_clk(clk), .i_resetn(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;

  function automatic longint wcoef(int w, int k);
    real x, f;
    x = 2.0 * PI * k / (N - 1);
    case (w)
      1: f = 0.5 - 0.5 * $cos(x);
      2: f = 0.54 - 0.46 * $cos(x);
      3: f = 0.42 - 0.5 * $cos(x) + 0.08 * $cos(2.0 * x);
      default: f = 1.0;
    endcase
    if (f < 0.0) f = 0.0;
    return longint'($rtoi(f * 262143.0 + 0.5));
  endfunction

  function automatic logic [31:0] apply(logic [31:0] d, int w, int k);
    longint p;
    if (w == 0) return d;
    p = longint'($signed(d)) * wcoef(w, k) + 64'sd131072;
    p = p >>> 18;
    return p[31:0];
  endfunction

  function automatic longint mag(logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    return s < 0 ? -s : s;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      mn = 0;
      mwin = 0;
      held = 0;
    end else begin
      if (held) begin
        chk("stable_valid", bus.res_valid, 1);
        chk("stable_i", bus.res_i, hi);
        chk("stable_q", bus.res_q, hq);
        chk("stable_last", bus.res_last, hl);
      end
      held = bus.res_valid && !bus.res_ready;
      hi = bus.res_i;
      hq = bus.res_q;
      hl = bus.res_last;
      if (bus.valid && bus.ready) begin
        if (mn == 0) mwin = int'(bus.window_sel);
        e.n = mn;
        e.in_mag = mag(bus.data_i);
        e.ei = apply(bus.data_i, mwin, mn);
        e.eq = apply(bus.data_q, mwin, mn);
        e.el = (mn == N - 1);
        q.push_back(e);
        if (lat_arm && t0 < 0) t0 = cyc;
        mn = (mn + 1) % N;
      end
      if (bus.res_valid && t0 >= 0 && t1 < 0) t1 = cyc;
      if (bus.res_valid && bus.res_ready) begin
        if (q.size() == 0) chk("stale_output", 1, 0);
        else begin
          r = q.pop_front();
          chk("out_i", bus.res_i, r.ei);
          chk("out_q", bus.res_q, r.eq);
          chk("out_last", bus.res_last, r.el);
          chk("mag_bound", mag(bus.res_i) <= r.in_mag, 1);
          got_i[r.n] = bus.res_i;
          out_cyc[r.n] = cyc;
          if (bus.res_last) last_cnt++;
        end
      end
    end
  end

  initial begin
    bus.res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.res_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [31:0] di, input logic [31:0] dq, input logic [1:0] sel);
    int b;
    b = 0;
    bus.data_i = di;
    bus.data_q = dq;
    bus.window_sel = sel;
    bus.valid = 1'b1;
    @(negedge clk);
    while (!bus.ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (!bus.ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((q.size() != 0 || bus.res_valid) && b < 300) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bus.valid = 1'b0;
    bus.data_i = '0;
    bus.data_q = '0;
    bus.window_sel = 2'd0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_last", bus.res_last, 0);
    chk("rst_data_i", bus.res_i, 0);
    chk("rst_data_q", bus.res_q, 0);
    chk("rst_ready", bus.ready, 1);
    chk("pin_hann_w0", wcoef(1, 0), 0);
    chk("pin_hamming_w0", wcoef(2, 0), 20971);
    chk("pin_blackman_w0", wcoef(3, 0), 0);
    chk("pin_apply_hamming", apply(32'd1000, 2, 0), 80);
    @(posedge clk);
    #1;
    // Hann on near-full-scale negative I: zero ends, symmetry, single last, 3-cycle latency
    lat_arm = 1;
    last_cnt = 0;
    for (int k = 0; k < N; k++) send(32'h8000_0001, 32'd0, 2'd1);
    drain();
    lat_arm = 0;
    chk("latency", t1 - t0, 3);
    chk("hann_n0", got_i[0], 0);
    chk("hann_n15", got_i[15], 0);
    chk("hann_sym_7_8", got_i[7], got_i[8]);
    chk("last_count", last_cnt, 1);
    // rectangular ramp: bit-exact, one per cycle
    for (int k = 0; k < N; k++) send(32'(k), ~32'(k), 2'd0);
    drain();
    for (int k = 0; k < N; k++) chk("rect_ramp", got_i[k], k);
    chk("rect_rate", out_cyc[15] - out_cyc[0], 15);
    // Hann with random back-pressure and bubbles
    rand_rdy = 1;
    for (int k = 0; k < 2 * N; k++) begin
      send(32'd1000, $urandom, 2'd1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 0;
    drain();
    // select change mid-frame only takes effect at the next frame
    for (int k = 0; k < N; k++) send(32'd1000, 32'd0, k < 5 ? 2'd1 : 2'd2);
    drain();
    chk("switch_keeps_hann_n15", got_i[15], 0);
    for (int k = 0; k < N; k++) send(32'd1000, 32'd0, 2'd2);
    drain();
    chk("hamming_n0", got_i[0], 80);
    // asynchronous reset mid-frame with samples in flight
    for (int k = 0; k < 10; k++) send(32'd500 + 32'(k), 32'd3, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.res_valid, 0);
    chk("async_rst_data", bus.res_i, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) send(32'd100 + 32'(k), 32'd7, 2'd0);
    drain();
    chk("post_rst_n0", got_i[0], 100);
    chk("post_rst_n15", got_i[15], 115);
    // full-scale Blackman
    for (int k = 0; k < N; k++) send(32'h8000_0000, 32'h7fff_ffff, 2'd3);
    drain();
    chk("blackman_n0", got_i[0], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
